// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: a start strobe launches n_pulses high pulses of
// hi_len cycles, separated by max(lo_len,1) low cycles, so every rising edge is detectable.
module pulse_train_gen #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   hi_len,
    input  logic [CNT_W-1:0]   lo_len,
    input  logic [BURST_W-1:0] n_pulses,
    output logic               sig_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   phase_cnt, phase_cnt_next;
    logic [BURST_W-1:0] pulse_cnt, pulse_cnt_next;
    logic [CNT_W-1:0]   hi_len_q, hi_len_next;
    logic [CNT_W-1:0]   lo_eff_q, lo_eff_next;
    logic               done_next;

    logic start_ok;
    logic phase_last;
    logic pulse_last;

    // abort wins over a simultaneous start while idle
    assign start_ok   = (state == IDLE) && start && !abort;
    // Counters run down to 1 so the full-scale loaded value never needs a wider register.
    assign phase_last = (phase_cnt == CNT_W'(1));
    assign pulse_last = (pulse_cnt == BURST_W'(1));

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; a missing default in a combinational block infers a latch.
    always_comb begin
        state_next     = state;
        phase_cnt_next = phase_cnt;
        pulse_cnt_next = pulse_cnt;
        hi_len_next    = hi_len_q;
        lo_eff_next    = lo_eff_q;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    hi_len_next = hi_len;
                    lo_eff_next = (lo_len == '0) ? CNT_W'(1) : lo_len;
                    if ((hi_len == '0) || (n_pulses == '0)) begin
                        done_next = 1'b1;
                    end else begin
                        state_next     = HIGH;
                        phase_cnt_next = hi_len;
                        pulse_cnt_next = n_pulses;
                    end
                end
            end

            HIGH: begin
                if (abort) begin
                    state_next     = IDLE;
                    phase_cnt_next = '0;
                    pulse_cnt_next = '0;
                end else if (phase_last) begin
                    if (pulse_last) begin
                        // no trailing low phase: IDLE provides the low level
                        state_next     = IDLE;
                        phase_cnt_next = '0;
                        pulse_cnt_next = '0;
                        done_next      = 1'b1;
                    end else begin
                        state_next     = LOW;
                        phase_cnt_next = lo_eff_q;
                        pulse_cnt_next = pulse_cnt - BURST_W'(1);
                    end
                end else begin
                    phase_cnt_next = phase_cnt - CNT_W'(1);
                end
            end

            LOW: begin
                if (abort) begin
                    state_next     = IDLE;
                    phase_cnt_next = '0;
                    pulse_cnt_next = '0;
                end else if (phase_last) begin
                    state_next     = HIGH;
                    phase_cnt_next = hi_len_q;
                end else begin
                    phase_cnt_next = phase_cnt - CNT_W'(1);
                end
            end

            default: begin
                state_next     = IDLE;
                phase_cnt_next = '0;
                pulse_cnt_next = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the statements are written in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            pulse_cnt <= '0;
            hi_len_q  <= '0;
            lo_eff_q  <= '0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_cnt_next;
            pulse_cnt <= pulse_cnt_next;
            hi_len_q  <= hi_len_next;
            lo_eff_q  <= lo_eff_next;
        end
    end

    // Outputs are flops decoded from the next state, so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            sig_out <= (state_next == HIGH);
            busy    <= (state_next != IDLE);
            done    <= done_next;
        end
    end

    a_sig_implies_busy : assert property (@(posedge clk) sig_out |-> busy);
    a_done_not_busy    : assert property (@(posedge clk) done |-> !busy);
    a_phase_nonzero    : assert property (@(posedge clk) (state != IDLE) |-> (phase_cnt != '0));
    a_pulse_nonzero    : assert property (@(posedge clk) (state != IDLE) |-> (pulse_cnt != '0));

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Programmable pulse-train generator: a one-cycle `start` strobe launches a burst of `n_pulses` high pulses on `sig_out`. Each pulse is `hi_len` cycles high, separated by `lo_len` cycles low. This block is the transmit-side counterpart of the rising-edge detectors in Common. It drives level/strobe lines (mute ramps, test tones, downstream trigger inputs) whose rising edges are consumed by those detectors. Every generated pulse is therefore separated by at least one low cycle, so each rising edge is detectable.

## Interface
- `CNT_W`, 16, width of `hi_len` / `lo_len` and the internal phase counter
- `BURST_W`, 8, width of `n_pulses` and the internal pulse counter

- `clk`  in  1  sole clock, all logic on posedge
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low
- `start`  in  1  launch strobe, sampled only when idle (`busy`=0)
- `abort`  in  1  terminate the burst immediately, sampled every cycle
- `hi_len`  in  CNT_W  high-phase length in cycles, latched on accepted `start`
- `lo_len`  in  CNT_W  low-phase length in cycles, latched on accepted `start`
- `n_pulses`  in  BURST_W  pulses per burst, latched on accepted `start`
- `sig_out`  out  1  generated pulse train, registered
- `busy`  out  1  burst in progress, registered
- `done`  out  1  one-cycle strobe on normal burst completion, registered

## Operation
- States:
  - IDLE: `sig_out`=0, `busy`=0.
  - HIGH: `sig_out`=1, `busy`=1.
  - LOW: `sig_out`=0, `busy`=1.
- Start acceptance:
  - `start` is accepted in IDLE when `abort`=0.
  - The accepting cycle latches `hi_len`, `lo_len` and `n_pulses`.
  - Input changes after acceptance have no effect on the current burst.
  - `start` while `busy`=1 is ignored. It is not queued.
- Effective low length: lo_eff = max(`lo_len`, 1). `lo_len`=0 is treated as 1 to guarantee a low cycle between pulses.
- Degenerate start: if the latched `hi_len`=0 or `n_pulses`=0, stay in IDLE. `sig_out` and `busy` remain 0, and `done`=1 for exactly one cycle on the next cycle.
- Normal start (IDLE -> HIGH):
  - The phase counter loads `hi_len`.
  - The pulse counter loads `n_pulses`.
- HIGH phase end: HIGH lasts exactly `hi_len` cycles, then:
  - If pulses remain after this one, go to LOW and load the phase counter with lo_eff.
  - Otherwise go to IDLE and assert `done` for one cycle.
- LOW phase end: LOW lasts exactly lo_eff cycles, then go to HIGH and reload the phase counter with `hi_len`.
- No trailing low phase follows the last pulse; IDLE supplies the low level.
- Abort:
  - `abort`=1 in HIGH or LOW: next cycle is IDLE with `sig_out`=0 and `busy`=0. `done` is not asserted.
  - `abort` in IDLE has no effect, except that it blocks a simultaneous `start` (abort wins).
- Maximum values:
  - `hi_len`=2^CNT_W-1 and `n_pulses`=2^BURST_W-1 are legal.
  - Counters must not wrap or overflow. Counting is down to 1, with no +1 widening of the loaded value.
- Reset:
  - `rst_n`=0 at any posedge forces IDLE with `sig_out`=0, `busy`=0, `done`=0.
  - Latched config and counters are cleared.
  - Reset mid-burst truncates the burst with no `done`.

## Timing
- `start` sampled at edge T (normal case):
  - `sig_out` rises and `busy` rises, both visible after edge T+1 (one cycle latency).
  - Pulse k (k=0..n-1) is high for cycles T+1+k·(hi+lo_eff) through T+k·(hi+lo_eff)+hi.
  - After the last high cycle, at cycle T+1+n·hi+(n-1)·lo_eff: `sig_out`=0, `busy`=0, `done`=1.
- Back-to-back bursts:
  - In the `done` cycle `busy`=0, so a `start` there is accepted.
  - The new burst's first high cycle follows after exactly one low cycle.
- Degenerate start at T: `done`=1 in cycle T+1 only.
- `abort` sampled at edge A during a burst: `sig_out`=0 and `busy`=0 from cycle A+1.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
- Reset then `hi_len`=3, `lo_len`=2, `n_pulses`=2, `start` at T -> `sig_out` is 1 in T+1..T+3, 0 in T+4..T+5, 1 in T+6..T+8. `done`=1 and `busy`=0 only at T+9. After reset, all outputs are 0 before `start`.
- `hi_len`=1, `lo_len`=0, `n_pulses`=4 -> `sig_out` sequence 1,0,1,0,1,0,1. `done` one cycle after the last 1. A rising-edge detector fed with `sig_out` counts exactly 4 edges.
- `hi_len`=0 or `n_pulses`=0 with `start` -> `sig_out` and `busy` stay 0, `done`=1 for one cycle at T+1. Repeat with the other field zero.
- Burst `hi_len`=5, `n_pulses`=3: `abort` in the 2nd high cycle of pulse 1 -> `sig_out` and `busy` are 0 next cycle, with no `done`. Assert `start`+`abort` together in IDLE -> no burst starts.
- Config inputs changed and `start` pulsed mid-burst -> burst timing matches the originally latched values, and no second burst runs. `start` in the `done` cycle -> new burst begins after exactly one low cycle.
- `rst_n`=0 for one cycle mid-HIGH of a `hi_len`=10 burst -> all outputs are 0 the next cycle, no `done`. A fresh `start` afterwards produces a full, correct burst.
